// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//   Scans ADC channels 0..NUM_CH-1 through an ADC0808-style converter. For
//   each channel it sets the address, pulses START/ALE, waits for EOC to fall
//   and rise again, pulses OE to read the result, and stores the value in a
//   per-channel register.
//
// Optional feature:
//   ADC_SCAN_AVG_EN - when defined, every channel is converted four times and
//   the truncated mean (sum >> 2) is stored.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              keep scanning while high
//   eoc                 ADC end-of-conversion (asynchronous to clk)
//   adc_data[7:0]       ADC output bus
//   start, ale, oe      ADC control strobes
//   add_a/add_b/add_c   channel address, LSB..MSB
//   rd_ch[2:0]          readback channel select
//   rd_data[7:0]        stored sample of rd_ch (00 for rd_ch >= NUM_CH)
//   smp_valid           one-cycle pulse when a sample is stored
//   smp_ch, smp_data    channel and value being stored
//   busy                sequencer is not idle
//   timeout_err         sticky flag, set when EOC never arrives
//   clr_err             clears timeout_err (a new timeout takes priority)
module adc_scan_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic       start,
  output logic       ale,
  output logic       oe,
  output logic       add_a,
  output logic       add_b,
  output logic       add_c,
  input  logic [2:0] rd_ch,
  output logic [7:0] rd_data,
  output logic       smp_valid,
  output logic [2:0] smp_ch,
  output logic [7:0] smp_data,
  output logic       busy,
  output logic       timeout_err,
  input  logic       clr_err
);

  // One shared cycle counter serves the settle, pulse and timeout intervals,
  // so it is sized for the longest of them.
  localparam int MAX_SP  = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int MAX_ALL = (TIMEOUT_CYC > MAX_SP) ? TIMEOUT_CYC : MAX_SP;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    LAST_CH     = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, START, WAIT_LO, WAIT_HI, READ, STORE
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      ptr;
  logic [2:0]      next_ptr;
  logic [2:0]      addr;
  logic [7:0]      cap;
  logic [7:0]      regs [8];
  logic            eoc_meta, eoc_sync;
  logic            tmo_hit;
  logic            read_last;

`ifdef ADC_SCAN_AVG_EN
  logic [9:0]      acc;
  logic [1:0]      conv;
  logic [9:0]      acc_sum;
  assign acc_sum = acc + {2'b00, adc_data};
`endif

  assign next_ptr  = (ptr == LAST_CH) ? 3'd0 : ptr + 3'd1;
  assign read_last = (state == READ) && (cnt == PULSE_LAST);

  // Two-flop synchronizer for the asynchronous EOC line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoc_meta <= 1'b0;
      eoc_sync <= 1'b0;
    end else begin
      eoc_meta <= eoc;
      eoc_sync <= eoc_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. A wait that runs out of time bypasses STORE and moves
  // straight on to the next channel.
  always_comb begin
    next_state = state;
    tmo_hit    = 1'b0;
    case (state)
      IDLE:    if (enable) next_state = ADDR;
      ADDR:    if (cnt == SETTLE_LAST) next_state = START;
      START:   if (cnt == PULSE_LAST) next_state = WAIT_LO;
      WAIT_LO: begin
        if (!eoc_sync) next_state = WAIT_HI;
        else if (cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = enable ? ADDR : IDLE;
        end
      end
      WAIT_HI: begin
        if (eoc_sync) next_state = READ;
        else if (cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = enable ? ADDR : IDLE;
        end
      end
      READ: begin
`ifdef ADC_SCAN_AVG_EN
        if (read_last) next_state = (conv == 2'd3) ? STORE : ADDR;
`else
        if (read_last) next_state = STORE;
`endif
      end
      STORE:   next_state = enable ? ADDR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. The address is held for the whole conversion and is
  // forced to zero only while idle.
  always_comb begin
    start     = 1'b0;
    ale       = 1'b0;
    oe        = 1'b0;
    smp_valid = 1'b0;
    smp_ch    = 3'd0;
    smp_data  = 8'h00;
    addr      = 3'd0;
    busy      = (state != IDLE);
    case (state)
      ADDR, WAIT_LO, WAIT_HI: addr = ptr;
      START: begin
        addr  = ptr;
        start = 1'b1;
        ale   = 1'b1;
      end
      READ: begin
        addr = ptr;
        oe   = 1'b1;
      end
      STORE: begin
        addr      = ptr;
        smp_valid = 1'b1;
        smp_ch    = ptr;
        smp_data  = cap;
      end
      default: ;
    endcase
  end

  assign add_a = addr[0];
  assign add_b = addr[1];
  assign add_c = addr[2];

  // Datapath: interval counter (restarted on every state change), channel
  // pointer, capture register, channel registers and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      ptr         <= 3'd0;
      cap         <= 8'h00;
      timeout_err <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
`ifdef ADC_SCAN_AVG_EN
      acc         <= 10'd0;
      conv        <= 2'd0;
`endif
    end else begin
      if (state != next_state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + 1'b1;

      if (state == STORE || tmo_hit) ptr <= next_ptr;

      if (state == STORE) regs[ptr] <= cap;

      if (tmo_hit)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

`ifdef ADC_SCAN_AVG_EN
      // A timeout in any of the four conversions throws the partial sum away.
      if (tmo_hit) begin
        acc  <= 10'd0;
        conv <= 2'd0;
      end else if (read_last) begin
        if (conv == 2'd3) begin
          cap  <= acc_sum[9:2];
          acc  <= 10'd0;
          conv <= 2'd0;
        end else begin
          acc  <= acc_sum;
          conv <= conv + 2'd1;
        end
      end
`else
      if (read_last) cap <= adc_data;
`endif
    end
  end

  // Combinational readback; unused channel slots read as zero.
  always_comb begin
    rd_data = 8'h00;
    if (int'(rd_ch) < NUM_CH) rd_data = regs[rd_ch];
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer
//   Directed bench for adc_scan_sequencer with default parameters. A small
//   ADC model answers each START with an EOC low/high sequence and presents
//   8'h10 + channel on the data bus (or a fixed four-sample table for the
//   averaging build).
module tb_adc_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       eoc = 1'b1;
  logic [7:0] adc_data;
  logic       start, ale, oe, add_a, add_b, add_c;
  logic [2:0] rd_ch = 3'd0;
  logic [7:0] rd_data;
  logic       smp_valid;
  logic [2:0] smp_ch;
  logic [7:0] smp_data;
  logic       busy, timeout_err;
  logic       clr_err = 1'b0;

  int pass_cnt = 0;
  int check_cnt = 0;
  int smp_seen = 0;

  logic       stuck = 1'b0;
  logic       avg_on = 1'b0;
  logic [1:0] avg_idx = 2'd0;
  logic [7:0] avg_tab [4];

  logic [2:0] addr;
  assign addr = {add_c, add_b, add_a};

  adc_scan_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .eoc(eoc), .adc_data(adc_data),
    .start(start), .ale(ale), .oe(oe), .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .rd_ch(rd_ch), .rd_data(rd_data), .smp_valid(smp_valid), .smp_ch(smp_ch),
    .smp_data(smp_data), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // ADC model: EOC drops 3 clocks after START rises and returns 20 clocks later.
  always begin
    @(posedge start);
    if (!stuck) begin
      repeat (3) @(posedge clk);
      #1 eoc = 1'b0;
      repeat (20) @(posedge clk);
      #1 eoc = 1'b1;
    end
  end

  always @(negedge oe) avg_idx = avg_idx + 2'd1;

  assign adc_data = avg_on ? avg_tab[avg_idx] : (8'h10 + {5'd0, addr});

  always @(negedge clk) if (smp_valid) smp_seen++;

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    clr_err = 1'b0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_sample(input int bound, output logic ok,
                             output logic [2:0] ch, output logic [7:0] d);
    ok = 1'b0;
    ch = 3'd0;
    d = 8'h00;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (smp_valid) begin
        ok = 1'b1;
        ch = smp_ch;
        d = smp_data;
        break;
      end
    end
  endtask

  task automatic wait_start_fall(input int bound, output logic ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!start && i < bound) begin @(negedge clk); i++; end
    while (start && i < bound) begin @(negedge clk); i++; end
    ok = (i < bound);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    @(negedge clk);
    v = {start, ale, oe, smp_valid, busy, timeout_err, 2'b00};
    check_cnt++;
    if (v !== 8'h00) $display("[TB] FAIL reset_ctrl got %b want 00000000", v);
    else pass_cnt++;
    check_cnt++;
    if (addr !== 3'd0) $display("[TB] FAIL reset_addr got %0d want 0", addr);
    else pass_cnt++;
    check_cnt++;
    if ({smp_ch, smp_data} !== 11'd0) $display("[TB] FAIL reset_smp got %h want 000", {smp_ch, smp_data});
    else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c);
      #1;
      check_cnt++;
      if (rd_data !== 8'h00) $display("[TB] FAIL reset_reg%0d got %h want 00", c, rd_data);
      else pass_cnt++;
    end
    do_reset();
    repeat (3) @(negedge clk);
    check_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL idle_busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_scan();
    logic ok;
    logic [2:0] ch;
    logic [7:0] d;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_sample(600, ok, ch, d);
      check_cnt++;
      if (!ok) $display("[TB] FAIL scan_wait%0d got no smp_valid want smp_valid", k);
      else pass_cnt++;
      check_cnt++;
      if (ch !== 3'(k % 4)) $display("[TB] FAIL scan_ch%0d got %0d want %0d", k, ch, k % 4);
      else pass_cnt++;
      check_cnt++;
      if (d !== 8'h10 + 8'(k % 4)) $display("[TB] FAIL scan_data%0d got %h want %h", k, d, 8'h10 + 8'(k % 4));
      else pass_cnt++;
    end
    enable = 1'b0;
    rd_ch = 3'd2;
    #1;
    check_cnt++;
    if (rd_data !== 8'h12) $display("[TB] FAIL rd_ch2 got %h want 12", rd_data);
    else pass_cnt++;
    rd_ch = 3'd3;
    #1;
    check_cnt++;
    if (rd_data !== 8'h13) $display("[TB] FAIL rd_ch3 got %h want 13", rd_data);
    else pass_cnt++;
    rd_ch = 3'd4;
    #1;
    check_cnt++;
    if (rd_data !== 8'h00) $display("[TB] FAIL rd_ch4 got %h want 00", rd_data);
    else pass_cnt++;
  endtask

  task automatic test_timing();
    int n, m, o, guard;
    logic addr_bad, ale_bad;
    do_reset();
    addr_bad = 1'b0;
    ale_bad = 1'b0;
    enable = 1'b1;
    guard = 0;
    while (!busy && guard < 10) begin @(negedge clk); guard++; end
    n = 0;
    while (!start && n < 50) begin
      n++;
      if (addr !== 3'd0) addr_bad = 1'b1;
      @(negedge clk);
    end
    check_cnt++;
    if (n != 8) $display("[TB] FAIL settle_len got %0d want 8", n);
    else pass_cnt++;
    m = 0;
    while (start && m < 50) begin
      m++;
      if (ale !== start || addr !== 3'd0) ale_bad = 1'b1;
      @(negedge clk);
    end
    check_cnt++;
    if (m != 4) $display("[TB] FAIL start_len got %0d want 4", m);
    else pass_cnt++;
    check_cnt++;
    if (ale_bad) $display("[TB] FAIL ale_with_start got mismatch want ale==start");
    else pass_cnt++;
    guard = 0;
    while (!oe && guard < 200) begin
      if (addr !== 3'd0) addr_bad = 1'b1;
      @(negedge clk);
      guard++;
    end
    o = 0;
    while (oe && o < 50) begin
      o++;
      if (addr !== 3'd0) addr_bad = 1'b1;
      @(negedge clk);
    end
    check_cnt++;
    if (o != 4) $display("[TB] FAIL oe_len got %0d want 4", o);
    else pass_cnt++;
    check_cnt++;
    if (addr_bad) $display("[TB] FAIL addr_stable got change want 0 held");
    else pass_cnt++;
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    logic ok;
    logic [2:0] ch;
    logic [7:0] d;
    int n, seen0;
    do_reset();
    stuck = 1'b1;
    enable = 1'b1;
    seen0 = smp_seen;
    wait_start_fall(100, ok);
    // Start-fall negedge is WAIT_LO cycle 1; after 4096 WAIT_LO cycles the
    // flag is visible on the following negedge.
    n = 1;
    while (!timeout_err && n < 5000) begin @(negedge clk); n++; end
    stuck = 1'b0;
    check_cnt++;
    if (timeout_err !== 1'b1) $display("[TB] FAIL tmo_set got %b want 1", timeout_err);
    else pass_cnt++;
    check_cnt++;
    if (n != 4097) $display("[TB] FAIL tmo_delay got %0d want 4097", n);
    else pass_cnt++;
    check_cnt++;
    if (smp_seen != seen0) $display("[TB] FAIL tmo_no_smp got %0d want %0d", smp_seen, seen0);
    else pass_cnt++;
    check_cnt++;
    if (addr !== 3'd1 || busy !== 1'b1) $display("[TB] FAIL tmo_next_ch got addr %0d busy %b want addr 1 busy 1", addr, busy);
    else pass_cnt++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_cnt++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL tmo_clr got %b want 0", timeout_err);
    else pass_cnt++;
    wait_sample(600, ok, ch, d);
    check_cnt++;
    if (!ok || ch !== 3'd1 || d !== 8'h11) $display("[TB] FAIL tmo_then_ch1 got ok %b ch %0d data %h want ok 1 ch 1 data 11", ok, ch, d);
    else pass_cnt++;
    rd_ch = 3'd0;
    #1;
    check_cnt++;
    if (rd_data !== 8'h00) $display("[TB] FAIL tmo_reg0 got %h want 00", rd_data);
    else pass_cnt++;
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic ok;
    logic [2:0] ch;
    logic [7:0] d;
    logic started;
    do_reset();
    enable = 1'b1;
    wait_sample(600, ok, ch, d);
    check_cnt++;
    if (!ok || ch !== 3'd0) $display("[TB] FAIL drop_ch0 got ok %b ch %0d want ok 1 ch 0", ok, ch);
    else pass_cnt++;
    wait_start_fall(100, ok);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    wait_sample(600, ok, ch, d);
    check_cnt++;
    if (!ok || ch !== 3'd1 || d !== 8'h11) $display("[TB] FAIL drop_ch1 got ok %b ch %0d data %h want ok 1 ch 1 data 11", ok, ch, d);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL drop_idle got busy %b want 0", busy);
    else pass_cnt++;
    started = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start || busy) started = 1'b1;
    end
    check_cnt++;
    if (started) $display("[TB] FAIL drop_stay_idle got activity want none");
    else pass_cnt++;
    enable = 1'b1;
    wait_sample(600, ok, ch, d);
    check_cnt++;
    if (!ok || ch !== 3'd2 || d !== 8'h12) $display("[TB] FAIL resume_ch2 got ok %b ch %0d data %h want ok 1 ch 2 data 12", ok, ch, d);
    else pass_cnt++;
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [2:0] ch;
    logic [7:0] d;
    int guard;
    do_reset();
    enable = 1'b1;
    wait_sample(600, ok, ch, d);
    wait_sample(600, ok, ch, d);
    guard = 0;
    while (!oe && guard < 600) begin @(negedge clk); guard++; end
    check_cnt++;
    if (!oe) $display("[TB] FAIL mid_reach_read got oe %b want 1", oe);
    else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    check_cnt++;
    if ({start, ale, oe, smp_valid, busy} !== 5'b0) $display("[TB] FAIL mid_async_ctrl got %b want 00000", {start, ale, oe, smp_valid, busy});
    else pass_cnt++;
    check_cnt++;
    if (addr !== 3'd0) $display("[TB] FAIL mid_async_addr got %0d want 0", addr);
    else pass_cnt++;
    rd_ch = 3'd0;
    #1;
    check_cnt++;
    if (rd_data !== 8'h00) $display("[TB] FAIL mid_reg0 got %h want 00", rd_data);
    else pass_cnt++;
    rd_ch = 3'd1;
    #1;
    check_cnt++;
    if (rd_data !== 8'h00) $display("[TB] FAIL mid_reg1 got %h want 00", rd_data);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    wait_sample(600, ok, ch, d);
    check_cnt++;
    if (!ok || ch !== 3'd0 || d !== 8'h10) $display("[TB] FAIL mid_restart got ok %b ch %0d data %h want ok 1 ch 0 data 10", ok, ch, d);
    else pass_cnt++;
    enable = 1'b0;
  endtask

`ifdef ADC_SCAN_AVG_EN
  task automatic test_avg();
    logic ok;
    logic [2:0] ch;
    logic [7:0] d;
    int seen0;
    do_reset();
    avg_tab[0] = 8'h01;
    avg_tab[1] = 8'h02;
    avg_tab[2] = 8'h03;
    avg_tab[3] = 8'h05;
    avg_idx = 2'd0;
    avg_on = 1'b1;
    seen0 = smp_seen;
    enable = 1'b1;
    wait_sample(600, ok, ch, d);
    enable = 1'b0;
    check_cnt++;
    if (!ok || ch !== 3'd0 || d !== 8'h02) $display("[TB] FAIL avg_data got ok %b ch %0d data %h want ok 1 ch 0 data 02", ok, ch, d);
    else pass_cnt++;
    check_cnt++;
    if (smp_seen != seen0 + 1) $display("[TB] FAIL avg_one_pulse got %0d want %0d", smp_seen - seen0, 1);
    else pass_cnt++;
    avg_on = 1'b0;
  endtask
`endif

  initial begin
    $display("[TB] adc_scan_sequencer bench start");
    test_reset();
    test_scan();
    test_timing();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
`ifdef ADC_SCAN_AVG_EN
    test_avg();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
